// File: rtl/vga_timing_pkg.sv
// VGA timing package: default 640x480 timing constants, count width and the
// run/drain FSM state encoding shared by the sync generator and its windows.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_TOTAL_COLS    = 800;
    localparam int DEF_TOTAL_ROWS    = 525;
    localparam int DEF_ACTIVE_COLS   = 640;
    localparam int DEF_ACTIVE_ROWS   = 480;
    localparam int DEF_H_FRONT_PORCH = 16;
    localparam int DEF_H_SYNC_WIDTH  = 96;
    localparam int DEF_V_FRONT_PORCH = 10;
    localparam int DEF_V_SYNC_WIDTH  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } vga_state_t;

endpackage

// File: rtl/vga_sync_window.sv
// Registered in-window flag: asserts when the (next) count lies in
// [start, start+length-1] and the (next) state is not IDLE. INACTIVE_LVL
// selects the polarity so active-low outputs come straight from the flop.
module vga_sync_window
    import vga_timing_pkg::*;
#(
    parameter logic INACTIVE_LVL = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [CNT_W-1:0] i_count,
    input  logic [CNT_W-1:0] i_start,
    input  logic [CNT_W-1:0] i_length,
    input  vga_state_t       i_state,
    output logic             o_flag
);

    logic             w_in_window;
    logic [CNT_W:0]   w_end_excl;
    logic             r_flag;

    // Window membership of the upcoming count; one extra bit keeps start+length from wrapping
    always_comb begin
        w_end_excl  = {1'b0, i_start} + {1'b0, i_length};
        w_in_window = (i_state != ST_IDLE) &&
                      ({1'b0, i_count} >= {1'b0, i_start}) &&
                      ({1'b0, i_count} <  w_end_excl);
    end

    // Register the flag so it lines up with the registered counts
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_flag <= INACTIVE_LVL;
        end else begin
            r_flag <= w_in_window ? ~INACTIVE_LVL : INACTIVE_LVL;
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA sync generator: col/row raster with a run/drain FSM that only stops on
// whole-frame boundaries. All outputs are decoded from the next count/state
// and registered, so syncs and frame_start align with the counts.
// Optional macro VGA_PORCH_SYNC_EN adds active-low monitor sync pulses;
// without it Hsync_pulse_o/Vsync_pulse_o are tied high.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
    parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
    parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
    parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
    parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
    parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    output logic             Hsync_o,
    output logic             Vsync_o,
    output logic [CNT_W-1:0] col_count_o,
    output logic [CNT_W-1:0] row_count_o,
    output logic             frame_start_o,
    output logic             busy_o,
    output logic             Hsync_pulse_o,
    output logic             Vsync_pulse_o
);

    localparam logic [CNT_W-1:0] L_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] L_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] L_COL_LAST = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] L_ROW_LAST = CNT_W'(TOTAL_ROWS - 1);
    localparam logic [CNT_W-1:0] L_ACT_COLS = CNT_W'(ACTIVE_COLS);
    localparam logic [CNT_W-1:0] L_ACT_ROWS = CNT_W'(ACTIVE_ROWS);

    vga_state_t       r_state;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic             r_frame_start;
    logic             r_busy;

    vga_state_t       w_next_state;
    logic [CNT_W-1:0] w_next_col;
    logic [CNT_W-1:0] w_next_row;
    logic             w_next_fs;
    logic             w_col_end;
    logic             w_row_end;
    logic             w_frame_end;

    // Next raster position, FSM state and frame-start decode
    always_comb begin
        w_col_end    = (r_col == L_COL_LAST);
        w_row_end    = (r_row == L_ROW_LAST);
        w_frame_end  = w_col_end && w_row_end;
        w_next_state = r_state;
        w_next_col   = r_col;
        w_next_row   = r_row;
        w_next_fs    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next_col = L_ZERO;
                w_next_row = L_ZERO;
                if (run_i) begin
                    w_next_state = ST_RUN;
                    w_next_fs    = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                w_next_col = w_col_end ? L_ZERO : (r_col + L_ONE);
                if (w_col_end) begin
                    w_next_row = w_row_end ? L_ZERO : (r_row + L_ONE);
                end else begin
                    w_next_row = r_row;
                end
                if (run_i) begin
                    w_next_state = ST_RUN;
                    w_next_fs    = w_frame_end;
                end else if ((r_state == ST_DRAIN) && w_frame_end) begin
                    // Drained a complete frame: park without a new frame_start
                    w_next_state = ST_IDLE;
                    w_next_col   = L_ZERO;
                    w_next_row   = L_ZERO;
                    w_next_fs    = 1'b0;
                end else begin
                    w_next_state = ST_DRAIN;
                    w_next_fs    = w_frame_end;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_col   = L_ZERO;
                w_next_row   = L_ZERO;
                w_next_fs    = 1'b0;
            end
        endcase
    end

    // State, counts, frame-start strobe and busy flag registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state       <= ST_IDLE;
            r_col         <= L_ZERO;
            r_row         <= L_ZERO;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_col         <= w_next_col;
            r_row         <= w_next_row;
            r_frame_start <= w_next_fs;
            r_busy        <= (w_next_state != ST_IDLE);
        end
    end

    assign col_count_o   = r_col;
    assign row_count_o   = r_row;
    assign frame_start_o = r_frame_start;
    assign busy_o        = r_busy;

    vga_sync_window #(.INACTIVE_LVL(1'b0)) u_h_active (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_count  (w_next_col),
        .i_start  (L_ZERO),
        .i_length (L_ACT_COLS),
        .i_state  (w_next_state),
        .o_flag   (Hsync_o)
    );

    vga_sync_window #(.INACTIVE_LVL(1'b0)) u_v_active (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_count  (w_next_row),
        .i_start  (L_ZERO),
        .i_length (L_ACT_ROWS),
        .i_state  (w_next_state),
        .o_flag   (Vsync_o)
    );

`ifdef VGA_PORCH_SYNC_EN
    localparam logic [CNT_W-1:0] L_HP_START = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [CNT_W-1:0] L_HP_LEN   = CNT_W'(H_SYNC_WIDTH);
    localparam logic [CNT_W-1:0] L_VP_START = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [CNT_W-1:0] L_VP_LEN   = CNT_W'(V_SYNC_WIDTH);

    vga_sync_window #(.INACTIVE_LVL(1'b1)) u_h_pulse (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_count  (w_next_col),
        .i_start  (L_HP_START),
        .i_length (L_HP_LEN),
        .i_state  (w_next_state),
        .o_flag   (Hsync_pulse_o)
    );

    vga_sync_window #(.INACTIVE_LVL(1'b1)) u_v_pulse (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_count  (w_next_row),
        .i_start  (L_VP_START),
        .i_length (L_VP_LEN),
        .i_state  (w_next_state),
        .o_flag   (Vsync_pulse_o)
    );
`else
    assign Hsync_pulse_o = 1'b1;
    assign Vsync_pulse_o = 1'b1;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a reduced raster so several
// frames fit in a short run. A behavioural raster model pushes the expected
// outputs for each edge into a queue; they are popped and compared after it.
module tb_vga_sync_gen;

    localparam int TC    = 20;
    localparam int TR    = 12;
    localparam int AC    = 12;
    localparam int AR    = 8;
    localparam int HFP   = 2;
    localparam int HSW   = 3;
    localparam int VFP   = 1;
    localparam int VSW   = 2;
    localparam int FRAME = TC * TR;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       busy;
        logic       hp;
        logic       vp;
    } exp_t;

    logic       clk_i;
    logic       rst_n_i;
    logic       run_i;
    logic       Hsync_o;
    logic       Vsync_o;
    logic [9:0] col_count_o;
    logic [9:0] row_count_o;
    logic       frame_start_o;
    logic       busy_o;
    logic       Hsync_pulse_o;
    logic       Vsync_pulse_o;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   md_state = 0;
    int   md_col   = 0;
    int   md_row   = 0;
    int   cycle    = 0;
    int   last_fs  = -1;
    int   fs_seen  = 0;

    vga_sync_gen #(
        .TOTAL_COLS    (TC),
        .TOTAL_ROWS    (TR),
        .ACTIVE_COLS   (AC),
        .ACTIVE_ROWS   (AR),
        .H_FRONT_PORCH (HFP),
        .H_SYNC_WIDTH  (HSW),
        .V_FRONT_PORCH (VFP),
        .V_SYNC_WIDTH  (VSW)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .run_i         (run_i),
        .Hsync_o       (Hsync_o),
        .Vsync_o       (Vsync_o),
        .col_count_o   (col_count_o),
        .row_count_o   (row_count_o),
        .frame_start_o (frame_start_o),
        .busy_o        (busy_o),
        .Hsync_pulse_o (Hsync_pulse_o),
        .Vsync_pulse_o (Vsync_pulse_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_col", 32'(col_count_o), 32'd0);
        check("rst_row", 32'(row_count_o), 32'd0);
        check("rst_hs", 32'(Hsync_o), 32'd0);
        check("rst_vs", 32'(Vsync_o), 32'd0);
        check("rst_fs", 32'(frame_start_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_hp", 32'(Hsync_pulse_o), 32'd1);
        check("rst_vp", 32'(Vsync_pulse_o), 32'd1);
    endtask

    // Advance the model one edge, queue its expectation, clock the DUT, compare
    task automatic tick();
        exp_t e;
        exp_t got;
        logic fe;
        logic fs;
        fs = 1'b0;
        if (md_state == 0) begin
            if (run_i) begin
                md_state = 1;
                md_col   = 0;
                md_row   = 0;
                fs       = 1'b1;
            end
        end else begin
            fe = (md_col == TC - 1) && (md_row == TR - 1);
            if (md_col == TC - 1) begin
                md_col = 0;
                md_row = (md_row == TR - 1) ? 0 : md_row + 1;
            end else begin
                md_col = md_col + 1;
            end
            if (!run_i && md_state == 2 && fe) begin
                md_state = 0;
                md_col   = 0;
                md_row   = 0;
            end else begin
                md_state = run_i ? 1 : 2;
                fs       = fe;
            end
        end
        e.col  = 10'(md_col);
        e.row  = 10'(md_row);
        e.busy = (md_state != 0);
        e.fs   = fs;
        e.hs   = e.busy && (md_col < AC);
        e.vs   = e.busy && (md_row < AR);
`ifdef VGA_PORCH_SYNC_EN
        e.hp   = !(e.busy && md_col >= AC + HFP && md_col < AC + HFP + HSW);
        e.vp   = !(e.busy && md_row >= AR + VFP && md_row < AR + VFP + VSW);
`else
        e.hp   = 1'b1;
        e.vp   = 1'b1;
`endif
        q.push_back(e);
        @(posedge clk_i);
        #1;
        cycle++;
        got = q.pop_front();
        check("col", 32'(col_count_o), 32'(got.col));
        check("row", 32'(row_count_o), 32'(got.row));
        check("hsync", 32'(Hsync_o), 32'(got.hs));
        check("vsync", 32'(Vsync_o), 32'(got.vs));
        check("frame_start", 32'(frame_start_o), 32'(got.fs));
        check("busy", 32'(busy_o), 32'(got.busy));
        check("hsync_pulse", 32'(Hsync_pulse_o), 32'(got.hp));
        check("vsync_pulse", 32'(Vsync_pulse_o), 32'(got.vp));
        if (frame_start_o === 1'b1) begin
            fs_seen++;
            if (last_fs >= 0) begin
                check("fs_interval", 32'(cycle - last_fs), 32'(FRAME));
            end
            last_fs = cycle;
        end
        if (md_state == 0) begin
            last_fs = -1;
        end
    endtask

    initial begin
        rst_n_i = 1'b0;
        run_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs();
        rst_n_i = 1'b1;
        repeat (3) tick();

        // Start: first edge gives the frame origin and a single-cycle strobe
        run_i = 1'b1;
        tick();
        check("start_fs", 32'(frame_start_o), 32'd1);
        check("start_busy", 32'(busy_o), 32'd1);
        tick();
        check("start_fs_one_cycle", 32'(frame_start_o), 32'd0);

        // Two free-running frames
        fs_seen = 0;
        repeat (2 * FRAME) tick();
        check("two_frames_fs_count", 32'(fs_seen), 32'd2);

        // Drop run mid-frame: finish the frame then go idle without a strobe
        for (int k = 0; k < FRAME && !(md_row == 2 && md_col == 0); k++) tick();
        run_i   = 1'b0;
        fs_seen = 0;
        for (int k = 0; k < 2 * FRAME && md_state != 0; k++) tick();
        check("drain_idle_busy", 32'(busy_o), 32'd0);
        check("drain_no_fs", 32'(fs_seen), 32'd0);
        check("drain_idle_col", 32'(col_count_o), 32'd0);
        repeat (3) tick();

        // Drop and re-raise run inside a frame: next strobe on the normal boundary
        run_i = 1'b1;
        tick();
        for (int k = 0; k < FRAME && md_row != 3; k++) tick();
        run_i = 1'b0;
        for (int k = 0; k < FRAME && md_row != 6; k++) tick();
        run_i   = 1'b1;
        fs_seen = 0;
        for (int k = 0; k < FRAME && fs_seen == 0; k++) tick();
        check("rerun_fs_seen", 32'(fs_seen), 32'd1);
        check("rerun_fs_col", 32'(col_count_o), 32'd0);
        check("rerun_fs_row", 32'(row_count_o), 32'd0);

        // Single-cycle run glitch must not disturb the outputs
        repeat (7) tick();
        run_i = 1'b0;
        tick();
        run_i = 1'b1;
        repeat (10) tick();
        check("glitch_busy", 32'(busy_o), 32'd1);

        // Asynchronous reset mid-frame takes effect before the next edge
        for (int k = 0; k < FRAME && md_row != 5; k++) tick();
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs();
        q.delete();
        md_state = 0;
        md_col   = 0;
        md_row   = 0;
        last_fs  = -1;
        run_i    = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        repeat (4) tick();
        check("post_reset_idle", 32'(busy_o), 32'd0);
        run_i = 1'b1;
        repeat (FRAME + 5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
